// File: rtl/gpio_cond_pkg.sv
// Shared defaults and helpers for the GPIO input conditioner.
package gpio_cond_pkg;

   localparam int unsigned DEFAULT_PRESCALE = 4;
   localparam int unsigned DEFAULT_STABLE   = 3;
   localparam int unsigned DEFAULT_CNT_W    = 4;

   function automatic int unsigned presc_width(input int unsigned prescale);
      return (prescale > 1) ? $clog2(prescale) : 1;
   endfunction

endpackage

// File: rtl/gpio_input_conditioner_cell.sv
// One pin of the conditioner: stability counter, debounced level and edge pulses.
module gpio_debounce_cell
   import gpio_cond_pkg::*;
#(
   parameter int unsigned STABLE    = DEFAULT_STABLE,
   parameter int unsigned CNT_W     = DEFAULT_CNT_W,
   parameter bit          RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic s2,
   input  logic oe,
   input  logic en,
   input  logic tick,
   output logic din,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             din_next;

   always_comb begin
      din_next = din;
      cnt_next = cnt;
      if (oe) begin
         din_next = s2;
         cnt_next = '0;
      end else if (!en) begin
         din_next = din;
      end else if (s2 == din) begin
         cnt_next = '0;
      end else if (tick && cnt == CNT_LAST) begin
         din_next = s2;
         cnt_next = '0;
      end else if (tick) begin
         cnt_next = cnt + CNT_W'(1);
      end
   end

   // Edge pulses are registered alongside din so they line up with the level change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         din  <= RESET_VAL;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         cnt  <= cnt_next;
         din  <= din_next;
         rise <= din_next & ~din;
         fall <= ~din_next & din;
      end
   end

endmodule

// File: rtl/gpio_input_conditioner.sv
// Pad-side input conditioner: per-pin synchroniser, shared debounce prescaler, filter cells.
module gpio_input_conditioner
   import gpio_cond_pkg::*;
#(
   parameter int unsigned N_PINS    = 32,
   parameter int unsigned PRESCALE  = DEFAULT_PRESCALE,
   parameter int unsigned STABLE    = DEFAULT_STABLE,
   parameter int unsigned CNT_W     = DEFAULT_CNT_W,
   parameter bit          RESET_VAL = 1'b0
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              en_i,
   input  logic [N_PINS-1:0] pad_i,
   input  logic [N_PINS-1:0] oe_i,
   output logic [N_PINS-1:0] din_o,
   output logic [N_PINS-1:0] rise_o,
   output logic [N_PINS-1:0] fall_o,
   output logic              tick_o
);

   localparam int unsigned     PW         = presc_width(PRESCALE);
   localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);

   logic [N_PINS-1:0] s1;
   logic [N_PINS-1:0] s2;
   logic [PW-1:0]     presc;
   logic              run;
   logic              tick;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= pad_i;
         s2 <= s1;
      end
   end

   // run keeps tick low while in reset even when PRESCALE=1 makes the compare constant.
   assign tick   = en_i & run & (presc == PRESC_LAST);
   assign tick_o = tick;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         presc <= '0;
         run   <= 1'b0;
      end else begin
         run <= 1'b1;
         if (!en_i || presc == PRESC_LAST) begin
            presc <= '0;
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

   for (genvar i = 0; i < N_PINS; i++) begin : g_pin
      gpio_debounce_cell #(
         .STABLE    (STABLE),
         .CNT_W     (CNT_W),
         .RESET_VAL (RESET_VAL)
      ) u_cell (
         .clk   (wb_clk_i),
         .rst_n (wb_rst_ni),
         .s2    (s2[i]),
         .oe    (oe_i[i]),
         .en    (en_i),
         .tick  (tick),
         .din   (din_o[i]),
         .rise  (rise_o[i]),
         .fall  (fall_o[i])
      );
   end

endmodule
